// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  // Controller states: waiting for a request, reading bytes, writing bytes.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Load/store size codes as presented on ls_size.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // mem_a[17:16] value that selects the I/O region.
  localparam logic [1:0] IO_SEL = 2'b11;

  // An instruction fetch always moves a full word.
  localparam logic [2:0] FETCH_BYTES = 3'd4;

  // Number of bus bytes for a size code; the unused code 3 moves a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests
// onto the 8-bit unified bus, one byte per ready cycle, registered outputs.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,

  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,

  input  logic        io_buffer_full,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        flush,

  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  // Transaction state
  state_t      state_q, state_d;
  logic        own_ls_q, own_ls_d;     // 1 = load/store owns the bus, 0 = fetch
  logic [31:0] addr_q, addr_d;         // base byte address
  logic [2:0]  n_q, n_d;               // bytes in this transaction
  logic [2:0]  k_q, k_d;               // next byte to issue
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;       // read bytes assembled so far
  logic        cap_q, cap_d;           // a read byte is owed from mem_din this edge
  logic [1:0]  cap_lane_q, cap_lane_d; // lane that owed byte lands in

  // Registered bus and response outputs
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  // Helpers
  logic [31:0] byte_addr;
  logic [31:0] rdata_cap;
  logic        all_issued;
  logic        io_blocked;

  // Address of byte k, I/O back-pressure check and read data with the owed byte merged in
  always_comb begin
    byte_addr  = addr_q + {29'd0, k_q};
    all_issued = (k_q == n_q);
    io_blocked = (byte_addr[17:16] == IO_SEL) && io_buffer_full;
    rdata_cap  = rdata_q;
    if (cap_q) begin
      rdata_cap[{cap_lane_q, 3'b000} +: 8] = mem_din;
    end
  end

  // Next-state and output logic for the IDLE/READ/WRITE sequencer
  always_comb begin
    state_d    = state_q;
    own_ls_d   = own_ls_q;
    addr_d     = addr_q;
    n_d        = n_q;
    k_d        = k_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_cap;   // an owed capture completes even while paused
    cap_d      = 1'b0;
    cap_lane_d = cap_lane_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (ls_req) begin
          own_ls_d = 1'b1;
          addr_d   = ls_addr;
          n_d      = size_to_bytes(ls_size);
          wdata_d  = ls_wdata;
          k_d      = 3'd0;
          rdata_d  = 32'd0;   // unused upper lanes read back as zero
          state_d  = ls_wr ? WRITE : READ;
        end else if (if_req && !flush) begin
          own_ls_d = 1'b0;
          addr_d   = if_addr;
          n_d      = FETCH_BYTES;
          k_d      = 3'd0;
          rdata_d  = 32'd0;
          state_d  = READ;
        end
      end

      READ: begin
        if (flush && !own_ls_q) begin
          // Mispredicted fetch: drop it, including any byte still in flight.
          state_d = IDLE;
          k_d     = 3'd0;
        end else if (rdy_in) begin
          if (!all_issued) begin
            mem_a_d    = byte_addr;
            cap_d      = 1'b1;
            cap_lane_d = k_q[1:0];
            k_d        = k_q + 3'd1;
          end else begin
            // Last byte is merged through rdata_cap on this same edge.
            state_d = IDLE;
            k_d     = 3'd0;
            if (own_ls_q) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = rdata_cap;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rdata_cap;
            end
          end
        end
      end

      WRITE: begin
        if (rdy_in) begin
          if (!all_issued) begin
            if (!io_blocked) begin
              mem_a_d    = byte_addr;
              mem_dout_d = wdata_q[{k_q[1:0], 3'b000} +: 8];
              mem_wr_d   = 1'b1;
              k_d        = k_q + 3'd1;
            end
          end else begin
            state_d   = IDLE;
            k_d       = 3'd0;
            ls_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      own_ls_q   <= 1'b0;
      addr_q     <= 32'd0;
      n_q        <= 3'd0;
      k_q        <= 3'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      cap_q      <= 1'b0;
      cap_lane_q <= 2'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      own_ls_q   <= own_ls_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      k_q        <= k_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cap_q      <= cap_d;
      cap_lane_q <= cap_lane_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of single requests plus hand-written
// sequences for arbitration, I/O back-pressure, bus pause, flush and reset.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        if_req, if_done, flush;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .flush(flush),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  // Sparse byte memory; unwritten bytes read as a fixed function of the address.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Bus model: commit a write byte, and present the byte for the address on the bus
  // so it is stable at the following rising edge.
  always @(negedge clk_in) begin
    if (mem_wr) mem[mem_a] = mem_dout;
    mem_din <= mem_rd(mem_a);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its done pulse.
  // lat = rising edges from the sampling edge E0 to the edge that registers done.
  task automatic run_req(input bit is_ls, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] data);
    if (is_ls) begin
      ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(negedge clk_in);
    lat = 0;
    while (!(is_ls ? ls_done : if_done) && lat < 40) begin
      @(negedge clk_in);
      lat++;
    end
    data = is_ls ? ls_rdata : if_data;
    if (lat >= 40) lat = -1;
    ls_req = 1'b0; if_req = 1'b0;
    @(negedge clk_in);
    chk("done_one_cycle", 32'(is_ls ? ls_done : if_done), 32'd0);
  endtask

  typedef struct {
    bit          is_ls;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    bit          chk_data;
    int          exp_lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int          lat, cyc, ls_cyc, if_cyc, wr_cnt, if_seen;
    logic [31:0] data, cap;

    vec[0]  = '{1'b0, 1'b0, SZ_W,  32'h0000_1000, 32'h0,         32'h0000_0513, 1'b1, 5};
    vec[1]  = '{1'b1, 1'b0, SZ_W,  32'h0000_1000, 32'h0,         32'h0000_0513, 1'b1, 5};
    vec[2]  = '{1'b1, 1'b0, SZ_B,  32'h0000_1001, 32'h0,         32'h0000_0005, 1'b1, 2};
    vec[3]  = '{1'b1, 1'b0, SZ_H,  32'h0001_FFFF, 32'h0,         32'h0000_1234, 1'b1, 3};
    vec[4]  = '{1'b1, 1'b1, SZ_W,  32'h0000_4000, 32'hCAFE_F00D, 32'h0,         1'b0, 5};
    vec[5]  = '{1'b1, 1'b0, SZ_W,  32'h0000_4000, 32'h0,         32'hCAFE_F00D, 1'b1, 5};
    vec[6]  = '{1'b1, 1'b1, SZ_H,  32'h0000_4010, 32'hAAAA_5566, 32'h0,         1'b0, 3};
    vec[7]  = '{1'b1, 1'b0, SZ_W,  32'h0000_4010, 32'h0,         32'hF6F7_5566, 1'b1, 5};
    vec[8]  = '{1'b1, 1'b0, 2'd3,  32'h0000_1000, 32'h0,         32'h0000_0513, 1'b1, 5};
    vec[9]  = '{1'b1, 1'b0, SZ_W,  32'hFFFF_FFFE, 32'h0,         32'hA4A5_A5A4, 1'b1, 5};
    vec[10] = '{1'b1, 1'b1, SZ_B,  32'h0000_5000, 32'h1234_5677, 32'h0,         1'b0, 2};
    vec[11] = '{1'b1, 1'b0, SZ_H,  32'h0000_5000, 32'h0,         32'h0000_F477, 1'b1, 3};

    mem[32'h0000_1000] = 8'h13;
    mem[32'h0000_1001] = 8'h05;
    mem[32'h0000_1002] = 8'h00;
    mem[32'h0000_1003] = 8'h00;
    mem[32'h0001_FFFF] = 8'h34;
    mem[32'h0002_0000] = 8'h12;

    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_ctl", {27'd0, mem_wr, if_done, ls_done, 2'b00}, 32'd0);
    chk("rst_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Table of single requests with no stalls
    for (int i = 0; i < NV; i++) begin
      run_req(vec[i].is_ls, vec[i].wr, vec[i].size, vec[i].addr, vec[i].wdata, lat, data);
      $display("vec %0d ls=%0d wr=%0d size=%0d addr=%h lat=%0d data=%h",
               i, vec[i].is_ls, vec[i].wr, vec[i].size, vec[i].addr, lat, data);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vec[i].exp_lat));
      if (vec[i].chk_data) chk($sformatf("vec%0d_data", i), data, vec[i].exp_data);
    end

    // Simultaneous fetch and store: store wins, fetch follows
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = SZ_W; ls_addr = 32'h2002; ls_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h1000;
    @(negedge clk_in);
    ls_cyc = -1; if_cyc = -1; cap = '0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (ls_done) begin ls_cyc = cyc; ls_req = 1'b0; end
      if (if_done) begin if_cyc = cyc; cap = if_data; if_req = 1'b0; break; end
      @(negedge clk_in);
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk_in);
    $display("arb ls_done@%0d if_done@%0d if_data=%h", ls_cyc, if_cyc, cap);
    chk("arb_ls_cyc", 32'(ls_cyc), 32'd5);
    chk("arb_if_cyc", 32'(if_cyc), 32'd11);
    chk("arb_if_data", cap, 32'h0000_0513);
    chk("arb_store_bytes",
        {mem_rd(32'h2005), mem_rd(32'h2004), mem_rd(32'h2003), mem_rd(32'h2002)}, 32'hDEAD_BEEF);

    // I/O store blocked by io_buffer_full at the first three issue edges
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = SZ_B; ls_addr = 32'h0003_0000; ls_wdata = 32'h41;
    io_buffer_full = 1'b1;
    @(negedge clk_in);
    ls_cyc = -1; wr_cnt = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (cyc >= 1 && cyc <= 3) chk($sformatf("io_blocked_wr_c%0d", cyc), 32'(mem_wr), 32'd0);
      wr_cnt += int'(mem_wr);
      if (ls_done) begin ls_cyc = cyc; ls_req = 1'b0; break; end
      if (cyc == 3) io_buffer_full = 1'b0;
      @(negedge clk_in);
    end
    ls_req = 1'b0; io_buffer_full = 1'b0;
    @(negedge clk_in);
    $display("io store ls_done@%0d writes=%0d byte=%h", ls_cyc, wr_cnt, mem_rd(32'h0003_0000));
    chk("io_ls_cyc", 32'(ls_cyc), 32'd5);
    chk("io_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("io_byte", {24'd0, mem_rd(32'h0003_0000)}, 32'h41);

    // Half load across 0x1FFFF/0x20000 with rdy_in low for two edges mid-transfer
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = SZ_H; ls_addr = 32'h0001_FFFF;
    @(negedge clk_in);
    ls_cyc = -1; cap = '0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (ls_done) begin ls_cyc = cyc; cap = ls_rdata; ls_req = 1'b0; break; end
      if (cyc == 1) rdy_in = 1'b0;
      if (cyc == 3) rdy_in = 1'b1;
      @(negedge clk_in);
    end
    ls_req = 1'b0; rdy_in = 1'b1;
    @(negedge clk_in);
    $display("rdy pause ls_done@%0d ls_rdata=%h", ls_cyc, cap);
    chk("rdy_ls_cyc", 32'(ls_cyc), 32'd5);
    chk("rdy_ls_data", cap, 32'h0000_1234);

    // Flush while fetch byte 2 is on the bus; a waiting load then proceeds
    if_req = 1'b1; if_addr = 32'h1000;
    @(negedge clk_in);
    ls_cyc = -1; if_seen = 0; cap = '0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (if_done) if_seen++;
      if (ls_done) begin ls_cyc = cyc; cap = ls_rdata; ls_req = 1'b0; break; end
      if (cyc == 3) begin
        flush = 1'b1; if_req = 1'b0;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = SZ_B; ls_addr = 32'h1001;
      end
      if (cyc == 4) begin
        flush = 1'b0;
        chk("flush_no_byte3", mem_a, 32'h0000_1002);
      end
      @(negedge clk_in);
    end
    ls_req = 1'b0; flush = 1'b0;
    @(negedge clk_in);
    if (if_done) if_seen++;
    $display("flush if_done_seen=%0d ls_done@%0d ls_rdata=%h", if_seen, ls_cyc, cap);
    chk("flush_no_if_done", 32'(if_seen), 32'd0);
    chk("flush_ls_cyc", 32'(ls_cyc), 32'd7);
    chk("flush_ls_data", cap, 32'h0000_0005);

    // Reset in the middle of a word store
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = SZ_W; ls_addr = 32'h6000; ls_wdata = 32'h1122_3344;
    @(negedge clk_in);
    ls_cyc = -1;
    for (cyc = 0; cyc < 12; cyc++) begin
      if (ls_done) ls_cyc = cyc;
      if (cyc == 2) begin rst_in = 1'b1; ls_req = 1'b0; end
      if (cyc == 3) begin
        chk("mid_rst_mem_a", mem_a, 32'd0);
        chk("mid_rst_ctl", {29'd0, mem_wr, ls_done, if_done}, 32'd0);
        chk("mid_rst_dout", {24'd0, mem_dout}, 32'd0);
        chk("mid_rst_data", ls_rdata | if_data, 32'd0);
        rst_in = 1'b0;
      end
      @(negedge clk_in);
    end
    $display("reset mid-store ls_done@%0d bytes=%h %h %h", ls_cyc,
             mem_rd(32'h6000), mem_rd(32'h6001), mem_rd(32'h6002));
    chk("mid_rst_no_done", 32'(ls_cyc), 32'hFFFF_FFFF);
    chk("mid_rst_written", {16'd0, mem_rd(32'h6001), mem_rd(32'h6000)}, 32'h0000_3344);
    chk("mid_rst_abandoned", {24'd0, mem_rd(32'h6002)}, 32'h0000_00C7);

    run_req(1'b1, 1'b0, SZ_B, 32'h1001, 32'h0, lat, data);
    $display("after reset load lat=%0d data=%h", lat, data);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_data", data, 32'h0000_0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
